// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store controller.
//   SZ_* access-size encodings carried on req_size
//   lsu_state_e controller states
//   AW_DEFAULT default memory word-address width
package lsu_pkg;

   localparam int unsigned AW_DEFAULT = 10;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2,
      SZ_RSVD = 2'd3
   } lsu_size_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_RDW,
      ST_WR,
      ST_RESP
   } lsu_state_e;

endpackage

// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: request/response handshake plus data-memory bus of lsu_ctrl.
//   req_*   : CPU request (valid/ready, we, size, sign, byte addr, wdata)
//   resp_*  : one-cycle completion pulse with load data and error flag
//   mem_*   : word-addressed memory strobes, address, write and read data
// Modports: master = CPU/memory side, slave = controller.
interface lsu_ctrl_if
   import lsu_pkg::*;
#(
   parameter int unsigned AW = AW_DEFAULT
);
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [1:0]    req_size;
   logic          req_sign;
   logic [31:0]   req_addr;
   logic [31:0]   req_wdata;
   logic          resp_valid;
   logic [31:0]   resp_rdata;
   logic          resp_err;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_din;
   logic          mem_write;
   logic          mem_read;
   logic [31:0]   mem_dout;

   modport master (
      output req_valid, req_we, req_size, req_sign, req_addr, req_wdata, mem_dout,
      input  req_ready, resp_valid, resp_rdata, resp_err,
             mem_addr, mem_din, mem_write, mem_read
   );

   modport slave (
      input  req_valid, req_we, req_size, req_sign, req_addr, req_wdata, mem_dout,
      output req_ready, resp_valid, resp_rdata, resp_err,
             mem_addr, mem_din, mem_write, mem_read
   );

endinterface

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational little-endian lane handling.
//   size_i  access size (byte/half/word)
//   sign_i  sign-extend loads when 1
//   off_i   byte offset within the word (already aligned to size)
//   rword_i word read from memory
//   wdata_i right-justified store data
//   load_o  extracted and extended load result
//   merge_o rword_i with the store lane(s) replaced
module lsu_lane_align
   import lsu_pkg::*;
(
   input  lsu_size_e   size_i,
   input  logic        sign_i,
   input  logic [1:0]  off_i,
   input  logic [31:0] rword_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] load_o,
   output logic [31:0] merge_o
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v  = rword_i[{off_i, 3'b000} +: 8];
      half_v  = off_i[1] ? rword_i[31:16] : rword_i[15:0];
      load_o  = rword_i;
      merge_o = wdata_i;
      unique case (size_i)
         SZ_BYTE: begin
            load_o  = {{24{sign_i & byte_v[7]}}, byte_v};
            merge_o = rword_i;
            merge_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
         end
         SZ_HALF: begin
            load_o  = {{16{sign_i & half_v[15]}}, half_v};
            merge_o = rword_i;
            if (off_i[1]) merge_o[31:16] = wdata_i[15:0];
            else          merge_o[15:0]  = wdata_i[15:0];
         end
         default: begin
            load_o  = rword_i;
            merge_o = wdata_i;
         end
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store controller between CPU datapath and word-addressed
// data memory. One request at a time; sub-word stores are read-modify-write.
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    lsu_ctrl_if.slave: req_*, resp_*, mem_* signals
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned half/word accesses
// complete immediately with resp_err=1 and no memory strobes. Without it the
// low address bits are cleared and the access proceeds.
module lsu_ctrl
   import lsu_pkg::*;
#(
   parameter int unsigned AW = AW_DEFAULT
)(
   input  logic        clk,
   input  logic        rst_n,
   lsu_ctrl_if.slave   bus
);

   lsu_state_e    state_q, state_d;
   logic          accept;
   logic          trap;
   lsu_size_e     size_n, size_q;
   logic [1:0]    off_n, off_q;
   logic          we_q, sign_q;
   logic [31:0]   wdata_q, mem_din_q, rdata_q;
   logic [31:0]   load_word, merge_word;
   logic [AW-1:0] mem_addr_q;
   logic          addr_hi_unused;

   assign addr_hi_unused = ^bus.req_addr[31:AW+2];

   // Reserved size behaves as a full word.
   assign size_n = (bus.req_size == SZ_RSVD) ? SZ_WORD : lsu_size_e'(bus.req_size);

   // Lane offset with misaligned low bits forced to zero.
   always_comb begin
      off_n = 2'b00;
      unique case (size_n)
         SZ_BYTE: off_n = bus.req_addr[1:0];
         SZ_HALF: off_n = {bus.req_addr[1], 1'b0};
         default: off_n = 2'b00;
      endcase
   end

`ifdef LSU_MISALIGN_TRAP_EN
   assign trap = ((size_n == SZ_HALF) && bus.req_addr[0]) ||
                 ((size_n == SZ_WORD) && (bus.req_addr[1:0] != 2'b00));
`else
   assign trap = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d        = state_q;
      accept         = 1'b0;
      bus.req_ready  = 1'b0;
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.resp_valid = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) begin
               accept = 1'b1;
               if (trap)                                state_d = ST_RESP;
               else if (bus.req_we && size_n == SZ_WORD) state_d = ST_WR;
               else                                     state_d = ST_RD;
            end
         end
         ST_RD: begin
            bus.mem_read = 1'b1;
            state_d      = ST_RDW;
         end
         ST_RDW:  state_d = we_q ? ST_WR : ST_RESP;
         ST_WR: begin
            bus.mem_write = 1'b1;
            state_d       = ST_RESP;
         end
         ST_RESP: begin
            bus.resp_valid = 1'b1;
            state_d        = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Request latch and datapath. mem_addr/mem_din only move when a memory
   // access is about to happen, so they hold their last value while idle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         we_q       <= 1'b0;
         sign_q     <= 1'b0;
         size_q     <= SZ_BYTE;
         off_q      <= 2'b00;
         wdata_q    <= '0;
         mem_addr_q <= '0;
         mem_din_q  <= '0;
         rdata_q    <= '0;
      end else begin
         if (accept) begin
            we_q    <= bus.req_we;
            sign_q  <= bus.req_sign;
            size_q  <= size_n;
            off_q   <= off_n;
            wdata_q <= bus.req_wdata;
            rdata_q <= '0;
            if (!trap) mem_addr_q <= bus.req_addr[AW+1:2];
            if (!trap && bus.req_we && size_n == SZ_WORD) mem_din_q <= bus.req_wdata;
         end
         if (state_q == ST_RDW) begin
            if (we_q) mem_din_q <= merge_word;
            else      rdata_q   <= load_word;
         end
      end
   end

`ifdef LSU_MISALIGN_TRAP_EN
   logic err_q;
   always_ff @(posedge clk) begin
      if (!rst_n)      err_q <= 1'b0;
      else if (accept) err_q <= trap;
   end
   assign bus.resp_err = err_q;
`else
   assign bus.resp_err = 1'b0;
`endif

   lsu_lane_align u_align (
      .size_i  (size_q),
      .sign_i  (sign_q),
      .off_i   (off_q),
      .rword_i (bus.mem_dout),
      .wdata_i (wdata_q),
      .load_o  (load_word),
      .merge_o (merge_word)
   );

   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_din    = mem_din_q;
   assign bus.resp_rdata = rdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: randomized self-checking bench for lsu_ctrl against a
// byte-array memory reference model.
module tb_lsu_ctrl;
   import lsu_pkg::*;

`ifdef LSU_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   lsu_ctrl_if #(.AW(10)) bus ();

   lsu_ctrl #(.AW(10)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [31:0] mem   [1024];
   logic [7:0]  ref_b [4096];
   int unsigned n_checks = 0;
   int unsigned n_errs   = 0;

   // Memory with one-cycle registered read.
   always @(posedge clk) begin
      if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_din;
      if (bus.mem_read)  bus.mem_dout <= mem[bus.mem_addr];
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic int unsigned nbytes(input logic [1:0] sz);
      return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
   endfunction

   function automatic logic [31:0] model_load(input logic [11:0] ea, input int unsigned nb, input logic sgn);
      logic [31:0] v;
      v = '0;
      for (int unsigned i = 0; i < nb; i++)
         v = v | (32'(ref_b[int'(ea) + int'(i)]) << (8 * i));
      if (sgn && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
      return v;
   endfunction

   function automatic logic [31:0] model_word(input logic [9:0] widx);
      logic [31:0] v;
      v = '0;
      for (int unsigned j = 0; j < 4; j++)
         v = v | (32'(ref_b[int'(widx) * 4 + int'(j)]) << (8 * j));
      return v;
   endfunction

   // Called at a falling edge with the DUT idle; returns at a falling edge
   // with the DUT idle again.
   task automatic do_req(input logic we, input logic [1:0] sz, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wd, input string tag);
      int unsigned nb, lat, rd_c, wr_c;
      logic [11:0] a12, ea;
      logic        mis, trp;
      logic [9:0]  widx;
      logic [31:0] exp_rdata, exp_din, junk;
      nb   = nbytes(sz);
      a12  = addr[11:0];
      mis  = (int'(a12) % nb) != 0;
      trp  = TRAP && mis;
      ea   = a12 - 12'(int'(a12) % nb);
      widx = ea[11:2];
      exp_rdata = '0; exp_din = '0; rd_c = 0; wr_c = 0;
      if (trp) lat = 1;
      else if (!we) begin
         lat = 3; rd_c = 1;
         exp_rdata = model_load(ea, nb, sgn);
      end else begin
         for (int unsigned i = 0; i < nb; i++) ref_b[int'(ea) + int'(i)] = wd[8*i +: 8];
         exp_din = model_word(widx);
         if (nb == 4) begin lat = 2; wr_c = 1; end
         else begin lat = 4; rd_c = 1; wr_c = 3; end
      end

      bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz;
      bus.req_sign  = sgn;  bus.req_addr = addr; bus.req_wdata = wd;
      check_eq({tag, ".ready0"}, 32'(bus.req_ready), 32'd1);
      @(posedge clk); #1;
      // Scramble the request lines; they must be ignored outside IDLE.
      junk = $urandom;
      bus.req_valid = 1'b0; bus.req_we = junk[0]; bus.req_size = junk[2:1];
      bus.req_sign = junk[3]; bus.req_addr = $urandom; bus.req_wdata = $urandom;

      for (int unsigned k = 1; k <= lat; k++) begin
         @(negedge clk);
         check_eq($sformatf("%s.rd%0d", tag, k), 32'(bus.mem_read),   32'(k == rd_c));
         check_eq($sformatf("%s.wr%0d", tag, k), 32'(bus.mem_write),  32'(k == wr_c));
         check_eq($sformatf("%s.rv%0d", tag, k), 32'(bus.resp_valid), 32'(k == lat));
         check_eq($sformatf("%s.rdy%0d", tag, k), 32'(bus.req_ready), 32'd0);
         if (k == rd_c || k == wr_c)
            check_eq($sformatf("%s.addr%0d", tag, k), 32'(bus.mem_addr), 32'(widx));
         if (k == wr_c) check_eq({tag, ".din"}, bus.mem_din, exp_din);
         if (k == lat) begin
            check_eq({tag, ".rdata"}, bus.resp_rdata, exp_rdata);
            check_eq({tag, ".err"}, 32'(bus.resp_err), 32'(trp));
         end
      end
      @(negedge clk);
      check_eq({tag, ".ready_after"}, 32'(bus.req_ready), 32'd1);
      check_eq({tag, ".rv_after"}, 32'(bus.resp_valid), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, ".ready"}, 32'(bus.req_ready),  32'd1);
      check_eq({tag, ".rv"},    32'(bus.resp_valid), 32'd0);
      check_eq({tag, ".rdata"}, bus.resp_rdata,      32'd0);
      check_eq({tag, ".err"},   32'(bus.resp_err),   32'd0);
      check_eq({tag, ".wr"},    32'(bus.mem_write),  32'd0);
      check_eq({tag, ".rd"},    32'(bus.mem_read),   32'd0);
      check_eq({tag, ".addr"},  32'(bus.mem_addr),   32'd0);
      check_eq({tag, ".din"},   bus.mem_din,         32'd0);
   endtask

   initial begin
      logic [31:0] w, addr, r;
      logic [31:0] exp_v;
      int unsigned n_acc, n_rsp;

      for (int unsigned i = 0; i < 1024; i++) begin
         w = $urandom;
         mem[i] = w;
         for (int unsigned j = 0; j < 4; j++) ref_b[i*4 + j] = w[8*j +: 8];
      end
      bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0;
      bus.req_sign = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;

      // Power-on reset
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("por");
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("por.ready_rel", 32'(bus.req_ready), 32'd1);

      // Directed cases
      do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, "st_w");
      do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        "ld_w");
      do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, "st_w2");
      do_req(1'b1, 2'd0, 1'b0, 32'h13, 32'h000000AA, "st_b");
      do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0,        "ld_bs");
      do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0,        "ld_bu");
      do_req(1'b0, 2'd1, 1'b1, 32'h12, 32'h0,        "ld_hs");
      do_req(1'b0, 2'd1, 1'b0, 32'h11, 32'h0,        "ld_hmis");
      do_req(1'b1, 2'd1, 1'b0, 32'h16, 32'h0000BEEF, "st_h");
      do_req(1'b0, 2'd3, 1'b0, 32'h14, 32'h0,        "ld_rsvd");
      do_req(1'b1, 2'd2, 1'b0, 32'h1A, 32'hCAFEF00D, "st_wmis");

      // Reset while a byte store sits in the read-capture cycle
      bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd0;
      bus.req_sign = 1'b0; bus.req_addr = 32'h21; bus.req_wdata = 32'h5A;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      @(negedge clk);
      check_eq("rst.rd1", 32'(bus.mem_read), 32'd1);
      @(negedge clk);
      check_eq("rst.wr2", 32'(bus.mem_write), 32'd0);
      rst_n = 1'b0;
      for (int unsigned c = 0; c < 2; c++) begin
         @(negedge clk);
         check_reset_outputs($sformatf("rst.in%0d", c));
      end
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_outputs("rst.rel");
      do_req(1'b0, 2'd0, 1'b0, 32'h21, 32'h0, "ld_after_rst");

      // req_valid held high: one accept per response, period latency+1
      exp_v = model_load(12'h010, 4, 1'b0);
      bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'd2;
      bus.req_sign = 1'b0; bus.req_addr = 32'h10; bus.req_wdata = '0;
      n_acc = 0; n_rsp = 0;
      for (int unsigned j = 0; j < 16; j++) begin
         if (j > 0) @(negedge clk);
         if (bus.req_ready)  n_acc++;
         if (bus.resp_valid) n_rsp++;
         check_eq($sformatf("hold.rdy%0d", j), 32'(bus.req_ready),  32'(j % 4 == 0));
         check_eq($sformatf("hold.rv%0d", j),  32'(bus.resp_valid), 32'(j % 4 == 3));
         if (j % 4 == 3) check_eq($sformatf("hold.rdata%0d", j), bus.resp_rdata, exp_v);
      end
      check_eq("hold.acc_vs_rsp", n_acc, n_rsp);
      @(negedge clk);
      bus.req_valid = 1'b0;

      // Randomized traffic, biased towards a small window for reuse
      for (int unsigned t = 0; t < 150; t++) begin
         addr = $urandom;
         r    = $urandom;
         if (r[0]) addr[11:0] = 12'($urandom_range(0, 63));
         do_req(r[1], r[3:2], r[4], addr, $urandom, $sformatf("rnd%0d", t));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
      $finish;
   end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store controller sitting between the CPU datapath and the word-addressed data memory. Accepts one load or store request at a time over a valid/ready handshake, drives the memory's address, write-data, write-strobe and read-strobe lines, and returns load data with sign/zero extension. Sub-word stores are performed as read-modify-write over the 32-bit memory word.

## Interface

Parameters:
- AW, 10, memory word-address width; mem_addr = req_addr[AW+1:2]

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = halfword, 2 = word, 3 = reserved (treated as word)
- req_sign  in  1  loads: 1 = sign-extend, 0 = zero-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle pulse: request complete
- resp_rdata  out  32  load result, valid with resp_valid; 0 for stores
- resp_err  out  1  misaligned-access flag, valid with resp_valid (see Configuration)
- mem_addr  out  AW  memory word address
- mem_din  out  32  memory write data
- mem_write  out  1  memory write strobe
- mem_read  out  1  memory read strobe
- mem_dout  in  32  memory read data, valid the cycle after mem_read is high

## Operation

- States: IDLE, RD, RDW, WR, RESP.
- IDLE: req_ready=1. On req_valid, latch we/size/sign/addr/wdata; next = WR if full-word store, else RD.
- RD: mem_read=1, mem_addr=latched word address; next RDW.
- RDW: capture mem_dout into word register. Load -> extract lane, extend, next RESP. Sub-word store -> merge wdata into lane(s), next WR.
- WR: mem_write=1, mem_din=merged (or full) word; next RESP.
- RESP: resp_valid=1 for exactly one cycle; next IDLE. No response backpressure.
- Little-endian lanes: byte lane = addr[1:0], halfword lane = addr[1]. Unselected bytes of a sub-word store are rewritten unchanged.
- Extension: byte from bit 7, halfword from bit 15, when req_sign=1; zero-fill otherwise.
- mem_read and mem_write never high in the same cycle; both low outside RD/WR. mem_addr/mem_din hold last value when idle.
- Reset (rst_n=0 at an edge): state=IDLE regardless of current state; in-flight request dropped, no response. Reset values: req_ready=1 after reset, resp_valid=0, resp_rdata=0, resp_err=0, mem_write=0, mem_read=0, mem_addr=0, mem_din=0.
- Request inputs ignored outside IDLE.

## Timing

- Accept at cycle 0 (req_valid & req_ready sampled high).
- Load: mem_read cycle 1, capture cycle 2, resp_valid cycle 3.
- Word store: mem_write cycle 1, resp_valid cycle 2.
- Byte/halfword store: mem_read cycle 1, merge cycle 2, mem_write cycle 3, resp_valid cycle 4.
- Next request accepted no earlier than the cycle after resp_valid; back-to-back throughput one request per (latency+1) cycles.

## Configuration

- LSU_MISALIGN_TRAP_EN defined: halfword with addr[0]=1 or word with addr[1:0]!=0 goes IDLE -> RESP directly, no memory strobes, resp_err=1, resp_rdata=0.
- Undefined: resp_err tied 0; misaligned low address bits forced to zero (halfword clears addr[0], word clears addr[1:0]) and access proceeds normally.

## Structure

- Shared package lsu_pkg: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), state enum, AW default.
- One sub-module natural: lsu_lane_align, combinational lane extract/extend for loads and lane merge for stores.

## Test plan

- Word store 0xDEADBEEF to addr 0x10, then word load 0x10 -> mem_write at cycle 1 with mem_addr=4; load resp_valid cycle 3, resp_rdata=0xDEADBEEF.
- Byte store 0xAA to addr 0x13 over word 0x11223344 -> one read, then mem_din=0xAA223344, resp at cycle 4.
- Signed byte load addr 0x13 of 0xAA223344 -> 0xFFFFFFAA; unsigned -> 0x000000AA; signed halfword addr 0x12 -> 0xFFFFAA22.
- Halfword load addr 0x11: with LSU_MISALIGN_TRAP_EN -> resp_err=1 cycle 1, no strobes; without -> reads halfword at 0x10.
- rst_n low during RDW of a store -> no mem_write, no resp_valid, req_ready=1 cycle after reset released, all outputs at reset values.
- req_valid held high continuously -> exactly one accept per response, req_ready low from cycle 1 until cycle after resp_valid.
